// File: rtl/tcp_output_uart_framer.sv
// tcp_output_uart_framer
// Store-and-forward framer that turns TCP output AXI-stream packets into a
// byte stream for the UART TX path. A whole packet is buffered, then emitted
// as SOF, TYPE, LEN_H, LEN_L and the kept payload bytes, low lane first.
// Optional build macro OUT_FRAMER_CHKSUM_EN appends a two's-complement
// checksum trailer covering TYPE, both length bytes and the payload.
`timescale 1ns/1ps
module tcp_output_uart_framer #(
    parameter int         DATA_WIDTH = 64,
    parameter int         MAX_BEATS  = 32,
    parameter logic [7:0] SOF_BYTE   = 8'hA5,
    parameter logic [7:0] FRAME_TYPE = 8'h03
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [7:0]              m_byte_data,
    output logic                    m_byte_valid,
    input  logic                    m_byte_ready,
    output logic                    busy,
    output logic [7:0]              drop_count
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(MAX_BEATS);
    localparam int PTR_W  = IDX_W + 1;
    localparam int LANE_W = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;
    localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(MAX_BEATS);

`ifdef OUT_FRAMER_CHKSUM_EN
    typedef enum logic [2:0] {
        ST_COLLECT, ST_DROP, ST_SOF, ST_TYPE, ST_LEN_H, ST_LEN_L, ST_PAYLOAD, ST_CHKSUM
    } state_t;
    localparam state_t ST_END = ST_CHKSUM;
`else
    typedef enum logic [2:0] {
        ST_COLLECT, ST_DROP, ST_SOF, ST_TYPE, ST_LEN_H, ST_LEN_L, ST_PAYLOAD
    } state_t;
    localparam state_t ST_END = ST_COLLECT;
`endif

    state_t state, state_next;

    // Input side goes live one clock after reset release so tready stays
    // low for the whole time rst_n is asserted.
    logic run;

    // wr_ptr counts every accepted beat (overflow detection); st_ptr counts
    // only beats that carry at least one kept byte, so the payload walk
    // never lands on an empty beat and never wastes an output cycle.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] st_ptr;
    logic [15:0]      byte_len;
    logic [15:0]      sent_cnt;

    logic [IDX_W-1:0]  rd_beat;
    logic [IDX_W-1:0]  rd_beat_nxt;
    logic [LANE_W-1:0] rd_lane;

    logic [KEEP_W-1:0][7:0] data_mem [MAX_BEATS];
    logic [KEEP_W-1:0]      keep_mem [MAX_BEATS];

    logic [KEEP_W-1:0] cur_keep;
    logic [7:0]        cur_byte;
    logic              more_in_beat;
    logic              accept;
    logic              overflow;
    logic              out_fire;
    logic              payload_done;

    function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] k);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + {15'd0, k[i]};
        end
        return n;
    endfunction

    // Lowest lane index >= from whose keep bit is set (0 when none).
    function automatic logic [LANE_W-1:0] lowest_lane_from(input logic [KEEP_W-1:0] k,
                                                           input int from);
        logic [LANE_W-1:0] r;
        r = '0;
        for (int i = KEEP_W - 1; i >= 0; i--) begin
            if (k[i] && (i >= from)) begin
                r = LANE_W'(i);
            end
        end
        return r;
    endfunction

    // True when some lane strictly above 'lane' is kept.
    function automatic logic has_lane_above(input logic [KEEP_W-1:0] k,
                                            input logic [LANE_W-1:0] lane);
        logic f;
        f = 1'b0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (k[i] && (i > int'(lane))) begin
                f = 1'b1;
            end
        end
        return f;
    endfunction

    assign s_axis_tready = run && ((state == ST_COLLECT) || (state == ST_DROP));
    assign busy          = !((state == ST_COLLECT) || (state == ST_DROP));
    assign m_byte_valid  = busy;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign out_fire      = busy && m_byte_ready;
    assign overflow      = (wr_ptr == FULL_PTR);
    assign rd_beat_nxt   = rd_beat + IDX_W'(1);
    assign cur_keep      = keep_mem[rd_beat];
    assign cur_byte      = data_mem[rd_beat][rd_lane];
    assign more_in_beat  = has_lane_above(cur_keep, rd_lane);
    assign payload_done  = (sent_cnt == (byte_len - 16'd1));

`ifdef OUT_FRAMER_CHKSUM_EN
    logic [7:0] csum;

    // Running sum of the covered bytes; restarted while SOF is on the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state == ST_SOF) begin
            csum <= '0;
        end else if (out_fire && (state != ST_CHKSUM)) begin
            csum <= csum + m_byte_data;
        end
    end
`endif

    // Arm the input side one clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output byte selection; output bytes come straight from
    // the state so they stay put while the UART side stalls.
    always_comb begin
        state_next  = state;
        m_byte_data = 8'h00;
        case (state)
            ST_COLLECT: begin
                if (accept) begin
                    if (overflow) begin
                        state_next = s_axis_tlast ? ST_COLLECT : ST_DROP;
                    end else if (s_axis_tlast) begin
                        state_next = ST_SOF;
                    end
                end
            end
            ST_DROP: begin
                if (accept && s_axis_tlast) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_SOF: begin
                m_byte_data = SOF_BYTE;
                if (out_fire) state_next = ST_TYPE;
            end
            ST_TYPE: begin
                m_byte_data = FRAME_TYPE;
                if (out_fire) state_next = ST_LEN_H;
            end
            ST_LEN_H: begin
                m_byte_data = byte_len[15:8];
                if (out_fire) state_next = ST_LEN_L;
            end
            ST_LEN_L: begin
                m_byte_data = byte_len[7:0];
                if (out_fire) state_next = (byte_len == 16'd0) ? ST_END : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                m_byte_data = cur_byte;
                if (out_fire && payload_done) state_next = ST_END;
            end
`ifdef OUT_FRAMER_CHKSUM_EN
            ST_CHKSUM: begin
                m_byte_data = 8'h00 - csum;
                if (out_fire) state_next = ST_COLLECT;
            end
`endif
            default: begin
                state_next = ST_COLLECT;
            end
        endcase
    end

    // Packet bookkeeping: write pointers, byte length, drop counter and the
    // payload read cursor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            st_ptr     <= '0;
            byte_len   <= '0;
            sent_cnt   <= '0;
            rd_beat    <= '0;
            rd_lane    <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        if (overflow) begin
                            wr_ptr   <= '0;
                            st_ptr   <= '0;
                            byte_len <= '0;
                            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
                        end else begin
                            wr_ptr   <= wr_ptr + PTR_W'(1);
                            byte_len <= byte_len + popcount(s_axis_tkeep);
                            if (|s_axis_tkeep) st_ptr <= st_ptr + PTR_W'(1);
                        end
                    end
                end
                ST_DROP: begin
                    if (accept && s_axis_tlast) begin
                        wr_ptr   <= '0;
                        st_ptr   <= '0;
                        byte_len <= '0;
                    end
                end
                ST_LEN_L: begin
                    if (out_fire) begin
                        rd_beat  <= '0;
                        rd_lane  <= lowest_lane_from(keep_mem[0], 0);
                        sent_cnt <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (out_fire) begin
                        sent_cnt <= sent_cnt + 16'd1;
                        if (more_in_beat) begin
                            rd_lane <= lowest_lane_from(cur_keep, int'(rd_lane) + 1);
                        end else begin
                            rd_beat <= rd_beat_nxt;
                            rd_lane <= lowest_lane_from(keep_mem[rd_beat_nxt], 0);
                        end
                    end
                end
                default: begin
                end
            endcase
            if (out_fire && (state_next == ST_COLLECT)) begin
                wr_ptr   <= '0;
                st_ptr   <= '0;
                byte_len <= '0;
            end
        end
    end

    // Packet storage; only beats with at least one kept byte are written.
    always_ff @(posedge clk) begin
        if ((state == ST_COLLECT) && accept && !overflow && (|s_axis_tkeep)) begin
            data_mem[st_ptr[IDX_W-1:0]] <= s_axis_tdata;
            keep_mem[st_ptr[IDX_W-1:0]] <= s_axis_tkeep;
        end
    end

endmodule

// File: tb/tb_tcp_output_uart_framer.sv
// Testbench for tcp_output_uart_framer (MAX_BEATS=4 so overflow is reachable).
// Expected frames come from a queue-based model of the frame format.
`timescale 1ns/1ps
module tb_tcp_output_uart_framer;

    localparam int DATA_WIDTH = 64;
    localparam int KEEP_W     = 8;
    localparam int MAX_BEATS  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [DATA_WIDTH-1:0] s_axis_tdata = '0;
    logic [KEEP_W-1:0]     s_axis_tkeep = '0;
    logic                  s_axis_tvalid = 1'b0;
    logic                  s_axis_tlast = 1'b0;
    logic                  s_axis_tready;
    logic [7:0]            m_byte_data;
    logic                  m_byte_valid;
    logic                  m_byte_ready = 1'b1;
    logic                  busy;
    logic [7:0]            drop_count;

    always #5 clk = ~clk;

    tcp_output_uart_framer #(
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BEATS (MAX_BEATS),
        .SOF_BYTE  (8'hA5),
        .FRAME_TYPE(8'h03)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_byte_data  (m_byte_data),
        .m_byte_valid (m_byte_valid),
        .m_byte_ready (m_byte_ready),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    logic [63:0] pkt_data[$];
    logic [7:0]  pkt_keep[$];

    // Record every byte that is about to transfer on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && m_byte_valid && m_byte_ready) got.push_back(m_byte_data);
    end

    // Frame format model: header, kept bytes in lane order, optional trailer.
    function automatic void add_expected();
        logic [7:0]  pay[$];
        logic [15:0] len;
        logic [7:0]  sum;
        for (int b = 0; b < pkt_data.size(); b++)
            for (int l = 0; l < KEEP_W; l++)
                if (pkt_keep[b][l]) pay.push_back(pkt_data[b][l*8 +: 8]);
        len = 16'(pay.size());
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h03);
        exp_q.push_back(len[15:8]);
        exp_q.push_back(len[7:0]);
        sum = 8'h03 + len[15:8] + len[7:0];
        foreach (pay[i]) begin
            exp_q.push_back(pay[i]);
            sum = sum + pay[i];
        end
`ifdef OUT_FRAMER_CHKSUM_EN
        exp_q.push_back(8'h00 - sum);
`endif
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic last,
                             output logic ok, output int waited);
        logic acc;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        ok = 1'b0;
        waited = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_packet(output logic ok, output int waits);
        logic b_ok;
        int   w;
        ok = 1'b1;
        waits = 0;
        for (int b = 0; b < pkt_data.size(); b++) begin
            send_beat(pkt_data[b], pkt_keep[b], (b == pkt_data.size() - 1), b_ok, w);
            ok = ok & b_ok;
            waits += w;
        end
    endtask

    // mode 0: ready held high; mode 2: ready randomised every cycle.
    task automatic wait_idle(input int mode, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            m_byte_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        @(posedge clk);
        #1;
        m_byte_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b expected 0", s_axis_tready); end
        n_checks++; if (m_byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", m_byte_valid); end
        n_checks++; if (m_byte_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", m_byte_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (drop_count !== 8'h00) begin n_fail++; $display("FAIL reset_drop: got %h expected 00", drop_count); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL release_tready: got %b expected 1", s_axis_tready); end
    endtask

    task automatic test_single();
        logic ok;
        int   w;
        got.delete(); exp_q.delete();
        pkt_data = '{64'h0807060504030201};
        pkt_keep = '{8'h0F};
        add_expected();
        m_byte_ready = 1'b1;
        send_packet(ok, w);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b expected 1", ok); end
        @(negedge clk);
        n_checks++;
        if (m_byte_valid !== 1'b1 || m_byte_data !== 8'hA5) begin
            n_fail++; $display("FAIL single_latency: got valid=%b data=%h expected valid=1 data=a5", m_byte_valid, m_byte_data);
        end
        wait_idle(0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: frame did not finish"); end
        n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d bytes expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_byte[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_three_beats();
        logic ok;
        int   w;
        got.delete(); exp_q.delete();
        pkt_data = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        pkt_keep = '{8'hFF, 8'hFF, 8'h07};
        add_expected();
        send_packet(ok, w);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL three_accept: got %b expected 1", ok); end
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
            n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL three_tready_busy: got %b expected 0", s_axis_tready); end
        end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL three_timeout: frame did not finish"); end
        n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL three_tready_after: got %b expected 1", s_axis_tready); end
        n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL three_count: got %0d bytes expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL three_byte[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_length();
        logic ok;
        int   w;
        got.delete(); exp_q.delete();
        pkt_data = '{{$urandom, $urandom}};
        pkt_keep = '{8'h00};
        add_expected();
        send_packet(ok, w);
        wait_idle(0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_timeout: frame did not finish"); end
        n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL zero_count: got %0d bytes expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero_byte[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic       ok;
        logic       stall_prev;
        logic [7:0] held;
        int         w;
        got.delete(); exp_q.delete();
        pkt_data = '{64'h0807060504030201};
        pkt_keep = '{8'h0F};
        add_expected();
        m_byte_ready = 1'b1;
        send_packet(ok, w);
        stall_prev = 1'b0;
        held = 8'h00;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (stall_prev && m_byte_valid) begin
                n_checks++; if (m_byte_data !== held) begin n_fail++; $display("FAIL bp_stable: got %h expected %h", m_byte_data, held); end
            end
            stall_prev = m_byte_valid && !m_byte_ready;
            held = m_byte_data;
            if (!busy) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            m_byte_ready = ~m_byte_ready;
        end
        @(posedge clk); #1;
        m_byte_ready = 1'b1;
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: frame did not finish"); end
        n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d bytes expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        logic ok;
        int   w;
        got.delete(); exp_q.delete();
        pkt_data.delete(); pkt_keep.delete();
        for (int b = 0; b < MAX_BEATS + 2; b++) begin
            pkt_data.push_back({$urandom, $urandom});
            pkt_keep.push_back(8'hFF);
        end
        send_packet(ok, w);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_accept: got %b expected 1", ok); end
        n_checks++; if (w != 0) begin n_fail++; $display("FAIL ovf_tready_stall: got %0d stall cycles expected 0", w); end
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL ovf_bytes: got %0d bytes expected 0", got.size()); end
        n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL ovf_drop_count: got %0d expected 1", drop_count); end
        pkt_data = '{{$urandom, $urandom}};
        pkt_keep = '{8'($urandom_range(1, 255))};
        add_expected();
        send_packet(ok, w);
        wait_idle(0, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_next_timeout: frame did not finish"); end
        n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_next_count: got %0d bytes expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_next_byte[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        int   w;
        int   f1;
        got.delete(); exp_q.delete();
        pkt_data = '{{$urandom, $urandom}, {$urandom, $urandom}};
        pkt_keep = '{8'hF0, 8'h3C};
        add_expected();
        f1 = exp_q.size();
        send_packet(ok, w);
        pkt_data = '{{$urandom, $urandom}};
        pkt_keep = '{8'hA5};
        add_expected();
        send_packet(ok, w);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b expected 1", ok); end
        n_checks++; if (w != f1) begin n_fail++; $display("FAIL b2b_hold_off: got %0d stall cycles expected %0d", w, f1); end
        wait_idle(0, ok);
        n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d bytes expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic ok;
        int   w;
        int   nb;
        for (int p = 0; p < 10; p++) begin
            got.delete(); exp_q.delete();
            pkt_data.delete(); pkt_keep.delete();
            nb = $urandom_range(1, MAX_BEATS);
            for (int b = 0; b < nb; b++) begin
                pkt_data.push_back({$urandom, $urandom});
                pkt_keep.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
            end
            add_expected();
            send_packet(ok, w);
            wait_idle(2, ok);
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand%0d_timeout: frame did not finish", p); end
            n_checks++; if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d bytes expected %0d", p, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte[%0d]: got %h expected %h", p, i, got[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        int   w;
        got.delete(); exp_q.delete();
        pkt_data = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        pkt_keep = '{8'hFF, 8'hFF, 8'hFF};
        send_packet(ok, w);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (got.size() >= 6) begin ok = 1'b1; break; end
        end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_reach: got %0d bytes expected 6", got.size()); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (m_byte_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", m_byte_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_tready: got %b expected 0", s_axis_tready); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        got.delete();
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL midrst_residual: got %0d bytes expected 0", got.size()); end
        n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL midrst_tready_after: got %b expected 1", s_axis_tready); end
        n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL midrst_drop: got %0d expected 0", drop_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_beats();
        test_zero_length();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
